// File: rtl/mem_access_unit.sv
// Four-state sequencer (IDLE/SETUP/ACCESS/DONE) between the controller and the 128x32 data memory.
// Optional MAU_INTERNAL_PC_EN: adds pc_out; fetches then read from pc_out and auto-increment it.
module mem_access_unit #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int WDATA_W   = 8,
  parameter int MEM_DEPTH = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [1:0]         op,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [WDATA_W-1:0] wdata_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  ir_out,
  output logic [DATA_W-1:0]  mdr_out,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata
`ifdef MAU_INTERNAL_PC_EN
  ,
  output logic [ADDR_W-1:0]  pc_out
`endif
);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 err_q, err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WDATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]    ir_q, ir_d;
  logic [DATA_W-1:0]    mdr_q, mdr_d;
  logic [ADDR_W-1:0]    req_addr;

`ifdef MAU_INTERNAL_PC_EN
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(MEM_DEPTH - 1);
  logic [ADDR_W-1:0]    pc_q, pc_d;

  assign req_addr = (op == OP_FETCH) ? pc_q : addr_in;
  assign pc_out   = pc_q;
`else
  assign req_addr = addr_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
`ifdef MAU_INTERNAL_PC_EN
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
`ifdef MAU_INTERNAL_PC_EN
      pc_q    <= pc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
`ifdef MAU_INTERNAL_PC_EN
    pc_d    = pc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          addr_d  = req_addr;
          wdata_d = wdata_in;
          err_d   = (op == OP_RSVD) || ({1'b0, req_addr} >= DEPTH_L);
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        // Read data is captured on the same edge the memory commits a store.
        if (!err_q) begin
          if (op_q == OP_FETCH) begin
            ir_d = mem_rdata;
`ifdef MAU_INTERNAL_PC_EN
            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
`endif
          end else if (op_q == OP_LOAD) begin
            mdr_d = mem_rdata;
          end
        end
        state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so mem_we cannot glitch and drops with reset.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign mem_we    = (state_q == S_ACCESS) && (op_q == OP_STORE) && !err_q;
  assign ir_out    = ir_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a behavioural memory and a transaction-level reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  addr_in = 8'd0;
  logic [7:0]  wdata_in = 8'd0;
  logic        busy, done, err, mem_we;
  logic [31:0] ir_out, mdr_out, mem_rdata;
  logic [7:0]  mem_addr, mem_wdata;
`ifdef MAU_INTERNAL_PC_EN
  logic [7:0]  pc_out;
`endif

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr_in(addr_in), .wdata_in(wdata_in),
    .busy(busy), .done(done), .err(err), .ir_out(ir_out), .mdr_out(mdr_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef MAU_INTERNAL_PC_EN
    , .pc_out(pc_out)
`endif
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, byte write on posedge, plus a preload port.
  logic [31:0] mem [0:127];
  logic        pl_en = 1'b0;
  logic [6:0]  pl_a = 7'd0;
  logic [31:0] pl_d = 32'd0;
  assign mem_rdata = (mem_addr < 8'd128) ? mem[mem_addr[6:0]] : 32'd0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (mem_we && mem_addr < 8'd128) mem[mem_addr[6:0]] <= {mem[mem_addr[6:0]][31:8], mem_wdata};
  end

  // Reference model state
  logic [31:0] ref_mem [0:127];
  logic [31:0] ref_ir, ref_mdr;
  logic [7:0]  ref_pc;
  int n_checks = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset_and_load();
    logic [31:0] d;
    reset = 1'b1;
    req = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      d = (i == 0) ? 32'h03C01005 : (i == 64) ? 32'd24 : $urandom;
      pl_en = 1'b1; pl_a = 7'(i); pl_d = d;
      ref_mem[i] = d;
    end
    @(negedge clk);
    pl_en = 1'b0;
    reset = 1'b0;
    ref_ir = 32'd0; ref_mdr = 32'd0; ref_pc = 8'd0;
  endtask

  task automatic do_access(input logic [1:0] o, input logic [7:0] a, input logic [7:0] w, input bit poke);
    logic [7:0] ea, we_a, we_d;
    bit e, got_done;
    int cyc, we_cnt;
    ea = a;
`ifdef MAU_INTERNAL_PC_EN
    if (o == 2'b00) ea = ref_pc;
`endif
    e = (o == 2'b11) || (ea >= 8'd128);
    @(negedge clk);
    req = 1'b1; op = o; addr_in = a; wdata_in = w;
    @(posedge clk);
    #1;
    req = 1'b0; op = 2'($urandom); addr_in = 8'($urandom); wdata_in = 8'($urandom);
    cyc = 0; we_cnt = 0; got_done = 0; we_a = 8'd0; we_d = 8'd0;
    while (!got_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 1) begin req = 1'b1; op = 2'b10; addr_in = 8'd5; wdata_in = 8'h55; end
      if (poke && cyc == 2) req = 1'b0;
      if (mem_we) begin we_cnt++; we_a = mem_addr; we_d = mem_wdata; end
      if (done) got_done = 1;
    end
    check_eq("done_seen", 32'(got_done), 32'd1);
    check_eq("latency", 32'(cyc), 32'd3);
    check_eq("err", 32'(err), 32'(e));
    if (!e) begin
      case (o)
        2'b00: begin
          ref_ir = ref_mem[ea[6:0]];
          ref_pc = (ref_pc == 8'd127) ? 8'd0 : ref_pc + 8'd1;
        end
        2'b01: ref_mdr = ref_mem[ea[6:0]];
        2'b10: ref_mem[ea[6:0]][7:0] = w;
        default: ;
      endcase
    end
    check_eq("ir_out", ir_out, ref_ir);
    check_eq("mdr_out", mdr_out, ref_mdr);
    check_eq("we_cycles", 32'(we_cnt), (o == 2'b10 && !e) ? 32'd1 : 32'd0);
    if (o == 2'b10 && !e) begin
      check_eq("we_addr", 32'(we_a), 32'(ea));
      check_eq("we_data", 32'(we_d), 32'(w));
      check_eq("mem_word", mem[ea[6:0]], ref_mem[ea[6:0]]);
    end
`ifdef MAU_INTERNAL_PC_EN
    check_eq("pc_out", 32'(pc_out), 32'(ref_pc));
`endif
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
    if (poke) begin
      repeat (2) begin
        @(negedge clk);
        check_eq("poke_ignored_busy", 32'(busy), 32'd0);
      end
      check_eq("poke_mem5", mem[5], ref_mem[5]);
    end
  endtask

  initial begin
    int ndone, last;
    logic [7:0] ha;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_ir", ir_out, 32'd0);
    check_eq("rst_mdr", mdr_out, 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    apply_reset_and_load();

    do_access(2'b00, 8'd0, 8'd0, 0);
    check_eq("ir_fetch0", ir_out, 32'h03C01005);
    do_access(2'b01, 8'd64, 8'd0, 0);
    check_eq("mdr_load64", mdr_out, 32'd24);
    do_access(2'b10, 8'd70, 8'hAA, 0);
    check_eq("mem70_byte", 32'(mem[70][7:0]), 32'hAA);
    do_access(2'b01, 8'd128, 8'd0, 0);
    do_access(2'b11, 8'd3, 8'd0, 0);
    do_access(2'b01, 8'd10, 8'd0, 1);

    // req held high: a new access every 4 cycles
    ha = 8'd33;
    @(negedge clk);
    req = 1'b1; op = 2'b01; addr_in = ha;
    ndone = 0; last = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) check_eq("hold_first", 32'(k), 32'd3);
        else check_eq("hold_gap", 32'(k - last), 32'd4);
        check_eq("hold_mdr", mdr_out, ref_mem[ha[6:0]]);
        last = k; ndone++;
      end
      if (k == 12) req = 1'b0;
    end
    check_eq("hold_count", 32'(ndone), 32'd3);
    ref_mdr = ref_mem[ha[6:0]];
    @(negedge clk);
    check_eq("hold_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++)
      do_access(2'($urandom_range(0, 3)), 8'($urandom_range(0, 159)), 8'($urandom), 0);

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    req = 1'b1; op = 2'b10; addr_in = 8'd9; wdata_in = ~ref_mem[9][7:0];
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("we_pre_reset", 32'(mem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("we_in_reset", 32'(mem_we), 32'd0);
    check_eq("busy_in_reset", 32'(busy), 32'd0);
    check_eq("done_in_reset", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("mem9_unchanged", mem[9], ref_mem[9]);
    check_eq("ir_after_reset", ir_out, 32'd0);
    reset = 1'b0;
    ref_ir = 32'd0; ref_mdr = 32'd0; ref_pc = 8'd0;
    do_access(2'b01, 8'd9, 8'd0, 0);

`ifdef MAU_INTERNAL_PC_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_ir = 32'd0; ref_mdr = 32'd0; ref_pc = 8'd0;
    for (int i = 0; i < 3; i++) begin
      do_access(2'b00, 8'($urandom), 8'd0, 0);
      check_eq("pc_seq", 32'(pc_out), 32'(i + 1));
      check_eq("ir_seq", ir_out, mem[i]);
    end
    for (int i = 3; i < 128; i++) do_access(2'b00, 8'($urandom), 8'd0, 0);
    check_eq("pc_wrap", 32'(pc_out), 32'd0);
    check_eq("ir_last", ir_out, mem[127]);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
